// File: rtl/tile_plotter.sv
// Tile plotter: on start, latches a tile origin and sprite select, raster-scans a
// TILE_W x TILE_H sprite from an external ROM and emits one VGA pixel per clock.
// Optional build macro: PLOT_TRANSPARENCY_EN (pixels equal to TRANSP_KEY are not plotted).
// ROM alignment: rom_data for the address presented in cycle t is captured by this
// block at the ROM_LAT-th rising edge after t, so pixel k is plotted ROM_LAT cycles
// after rom_addr=k.
module tile_plotter #(
  parameter int unsigned TILE_W  = 12,
  parameter int unsigned TILE_H  = 12,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned COLOR_W = 18,
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned ROM_LAT = 1,
  parameter logic [COLOR_W-1:0] TRANSP_KEY = '0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [SEL_W-1:0]   select,
  output logic [SEL_W-1:0]   rom_sel,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               plot,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done
);

  localparam int unsigned N     = TILE_W * TILE_H;
  localparam int unsigned COL_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned ROW_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int unsigned DRN_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [X_W-1:0]     x_base_q, x_base_d;
  logic [Y_W-1:0]     y_base_q, y_base_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               plot_q, busy_q, done_q;
  logic               plot_d, busy_d, done_d;
  logic [X_W-1:0]     x_out_q;
  logic [Y_W-1:0]     y_out_q;
  logic [COLOR_W-1:0] color_q;

  logic               scan_v, tail_v;
  logic [X_W-1:0]     scan_x, tail_x;
  logic [Y_W-1:0]     scan_y, tail_y;

  // Next-state and scan counter logic
  always_comb begin
    state_d  = state_q;
    x_base_d = x_base_q;
    y_base_d = y_base_q;
    sel_d    = sel_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    drain_d  = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SCAN;
          x_base_d = x_in;
          y_base_d = y_in;
          sel_d    = select;
          col_d    = '0;
          row_d    = '0;
          addr_d   = '0;
        end
      end
      S_SCAN: begin
        if (addr_q == ADDR_W'(N - 1)) begin
          state_d = S_DRAIN;
          drain_d = DRN_W'(ROM_LAT - 1);
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == COL_W'(TILE_W - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRN_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SCAN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Pixel coordinate of the address currently presented to the ROM
  always_comb begin
    scan_v = (state_q == S_SCAN);
    scan_x = x_base_q + X_W'(col_q);
    scan_y = y_base_q + Y_W'(row_q);
  end

  // Delay (x, y, valid) so they meet rom_data at the output register
  if (ROM_LAT == 1) begin : g_nopipe
    assign tail_v = scan_v;
    assign tail_x = scan_x;
    assign tail_y = scan_y;
  end else begin : g_pipe
    localparam int unsigned D = ROM_LAT - 1;
    logic [D-1:0]   v_q;
    logic [X_W-1:0] x_q [D];
    logic [Y_W-1:0] y_q [D];

    // Coordinate/valid shift register
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        v_q <= '0;
        for (int i = 0; i < int'(D); i++) begin
          x_q[i] <= '0;
          y_q[i] <= '0;
        end
      end else begin
        v_q[0] <= scan_v;
        x_q[0] <= scan_x;
        y_q[0] <= scan_y;
        for (int i = 1; i < int'(D); i++) begin
          v_q[i] <= v_q[i-1];
          x_q[i] <= x_q[i-1];
          y_q[i] <= y_q[i-1];
        end
      end
    end

    assign tail_v = v_q[D-1];
    assign tail_x = x_q[D-1];
    assign tail_y = y_q[D-1];
  end

`ifdef PLOT_TRANSPARENCY_EN
  assign plot_d = tail_v && (rom_data != TRANSP_KEY);
`else
  logic unused_key;
  assign plot_d     = tail_v;
  assign unused_key = ^TRANSP_KEY;
`endif

  // State, scan counters and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      x_base_q <= '0;
      y_base_q <= '0;
      sel_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      drain_q  <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_base_q <= x_base_d;
      y_base_q <= y_base_d;
      sel_q    <= sel_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (plot_d) begin
        x_out_q <= tail_x;
        y_out_q <= tail_y;
        color_q <= rom_data;
      end
    end
  end

  assign rom_sel  = sel_q;
  assign rom_addr = addr_q;
  assign plot     = plot_q;
  assign x_out    = x_out_q;
  assign y_out    = y_out_q;
  assign color    = color_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tile_plotter.sv
// Scoreboard bench for tile_plotter: a 12x12 ROM_LAT=1 instance and a 6x6 ROM_LAT=3 instance.
module tb_tile_plotter;

  typedef struct packed {
    logic [17:0] c;
    logic [7:0]  x;
    logic [6:0]  y;
  } pix_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters
  logic        start_a = 1'b0;
  logic [7:0]  x_in_a = '0;
  logic [6:0]  y_in_a = '0;
  logic [1:0]  sel_a = '0;
  logic [1:0]  rom_sel_a;
  logic [7:0]  rom_addr_a;
  logic [17:0] rom_data_a;
  logic        plot_a, busy_a, done_a;
  logic [7:0]  x_out_a;
  logic [6:0]  y_out_a;
  logic [17:0] color_a;

  // Instance B: 6x6 tile, three-cycle ROM
  logic        start_b = 1'b0;
  logic [7:0]  x_in_b = '0;
  logic [6:0]  y_in_b = '0;
  logic [1:0]  sel_b = '0;
  logic [1:0]  rom_sel_b;
  logic [7:0]  rom_addr_b;
  logic [17:0] rom_data_b, rom_d1_b;
  logic        plot_b, busy_b, done_b;
  logic [7:0]  x_out_b;
  logic [6:0]  y_out_b;
  logic [17:0] color_b;

  tile_plotter u_dut_a (
    .clock(clock), .resetn(resetn), .start(start_a),
    .x_in(x_in_a), .y_in(y_in_a), .select(sel_a),
    .rom_sel(rom_sel_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .plot(plot_a), .x_out(x_out_a), .y_out(y_out_a), .color(color_a),
    .busy(busy_a), .done(done_a)
  );

  tile_plotter #(.TILE_W(6), .TILE_H(6), .ROM_LAT(3)) u_dut_b (
    .clock(clock), .resetn(resetn), .start(start_b),
    .x_in(x_in_b), .y_in(y_in_b), .select(sel_b),
    .rom_sel(rom_sel_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .plot(plot_b), .x_out(x_out_b), .y_out(y_out_b), .color(color_b),
    .busy(busy_b), .done(done_b)
  );

  // Sprite ROM contents; sprite 3 has its first 100 pixels at colour 0
  function automatic logic [17:0] rom_val(input int s, input int a);
    if (s == 3 && a < 100) return 18'(0);
    return 18'(s * 4096 + a * 3 + 5);
  endfunction

  always_comb rom_data_a = rom_val(int'(rom_sel_a), int'(rom_addr_a));

  always @(posedge clock) begin
    rom_d1_b   <= rom_val(int'(rom_sel_b), int'(rom_addr_b));
    rom_data_b <= rom_d1_b;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  pix_t exp_a[$], exp_b[$], log_a[$];
  pix_t ea, eb;

  task automatic push_tile(input bit to_b, input int w, input int h,
                           input int x0, input int y0, input int s);
    pix_t p;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        p.x = 8'(x0 + c);
        p.y = 7'(y0 + r);
        p.c = rom_val(s, r * w + c);
        if (to_b) exp_b.push_back(p);
        else      exp_a.push_back(p);
      end
  endtask

  // Monitor A: pop and compare each plotted pixel, check tile shape at done
  int plots_a = 0, done_cnt_a = 0, first_cyc_a = 0, last_cyc_a = 0;
  int done_cyc_a = 0, gap_a = 0, addr0_cyc_a = 0, lat_a = 0;
  bit prev_plot_a = 0, addr0_seen_a = 0;
  always @(negedge clock) begin
    if (!resetn) begin
      plots_a = 0;
      prev_plot_a = 0;
      addr0_seen_a = 0;
    end else begin
      if (busy_a && rom_addr_a == 8'd0 && !addr0_seen_a) begin
        addr0_seen_a = 1;
        addr0_cyc_a = cyc;
      end
      if (plot_a) begin
        plots_a++;
        if (plots_a == 1) begin
          first_cyc_a = cyc;
          gap_a = cyc - done_cyc_a;
          lat_a = cyc - addr0_cyc_a;
        end
        last_cyc_a = cyc;
        log_a.push_back(pix_t'{c: color_a, x: x_out_a, y: y_out_a});
        if (exp_a.size() == 0) check("a_unexpected_plot", 1, 0);
        else begin
          ea = exp_a.pop_front();
          check("a_x", x_out_a, ea.x);
          check("a_y", y_out_a, ea.y);
          check("a_color", color_a, ea.c);
        end
      end
      if (done_a) begin
        check("a_done_plot_count", plots_a, 144);
        check("a_contiguous", last_cyc_a - first_cyc_a + 1, 144);
        check("a_done_after_last_plot", prev_plot_a, 1);
        check("a_busy_low_at_done", busy_a, 0);
        done_cnt_a++;
        done_cyc_a = cyc;
        plots_a = 0;
        addr0_seen_a = 0;
      end
      prev_plot_a = plot_a;
    end
  end

  // Monitor B
  int plots_b = 0, done_cnt_b = 0, addr0_cyc_b = 0, lat_b = 0;
  bit prev_plot_b = 0, addr0_seen_b = 0;
  always @(negedge clock) begin
    if (!resetn) begin
      plots_b = 0;
      prev_plot_b = 0;
      addr0_seen_b = 0;
    end else begin
      if (busy_b && rom_addr_b == 8'd0 && !addr0_seen_b) begin
        addr0_seen_b = 1;
        addr0_cyc_b = cyc;
      end
      if (plot_b) begin
        plots_b++;
        if (plots_b == 1) lat_b = cyc - addr0_cyc_b;
        if (exp_b.size() == 0) check("b_unexpected_plot", 1, 0);
        else begin
          eb = exp_b.pop_front();
          check("b_x", x_out_b, eb.x);
          check("b_y", y_out_b, eb.y);
          check("b_color", color_b, eb.c);
        end
      end
      if (done_b) begin
        check("b_done_plot_count", plots_b, 36);
        check("b_done_after_last_plot", prev_plot_b, 1);
        check("b_busy_low_at_done", busy_b, 0);
        done_cnt_b++;
        plots_b = 0;
        addr0_seen_b = 0;
      end
      prev_plot_b = plot_b;
    end
  end

  task automatic start_tile_a(input int x, input int y, input int s);
    @(posedge clock); #1;
    x_in_a = 8'(x); y_in_a = 7'(y); sel_a = 2'(s); start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int base, input int limit);
    int n = 0;
    while (done_cnt_a == base && n < limit) begin @(posedge clock); n++; end
    check("a_done_seen", done_cnt_a > base, 1);
  endtask

  task automatic wait_busy_a(input int limit);
    int n = 0;
    #1;
    while (!busy_a && n < limit) begin @(posedge clock); #1; n++; end
    check("a_busy_rise", busy_a, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_plot", plot_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rom_addr", rom_addr_a, 0);
    check("rst_color", color_a, 0);
    resetn = 1'b1;

    // Basic tile at (10,20), sprite 2
    log_a.delete();
    push_tile(0, 12, 12, 10, 20, 2);
    base = done_cnt_a;
    start_tile_a(10, 20, 2);
    wait_done_a(base, 400);
    check("a_first_latency", lat_a, 1);
    check("a_log_size", log_a.size(), 144);
    if (log_a.size() == 144) begin
      check("a_p0_x", log_a[0].x, 10);
      check("a_p0_y", log_a[0].y, 20);
      check("a_p0_color", log_a[0].c, 8197);
      check("a_p12_x", log_a[12].x, 10);
      check("a_p12_y", log_a[12].y, 21);
      check("a_p143_x", log_a[143].x, 21);
      check("a_p143_y", log_a[143].y, 31);
    end

    // Coordinate wrap at (250,120)
    log_a.delete();
    push_tile(0, 12, 12, 250, 120, 1);
    base = done_cnt_a;
    start_tile_a(250, 120, 1);
    wait_done_a(base, 400);
    check("wrap_log_size", log_a.size(), 144);
    if (log_a.size() == 144) begin
      check("wrap_col5_x", log_a[5].x, 255);
      check("wrap_col6_x", log_a[6].x, 0);
      check("wrap_row7_y", log_a[84].y, 127);
      check("wrap_row8_y", log_a[96].y, 0);
    end

    // Sprite with zero pixels: every pixel still plotted
    log_a.delete();
    push_tile(0, 12, 12, 0, 0, 3);
    base = done_cnt_a;
    start_tile_a(0, 0, 3);
    wait_done_a(base, 400);
    check("zero_log_size", log_a.size(), 144);
    if (log_a.size() == 144) begin
      check("zero_p0_color", log_a[0].c, 0);
      check("zero_p100_color", log_a[100].c, 12593);
    end

    // Back-to-back with start held high; mid-tile input changes apply only to the next tile
    base = done_cnt_a;
    push_tile(0, 12, 12, 30, 40, 0);
    @(posedge clock); #1;
    x_in_a = 8'd30; y_in_a = 7'd40; sel_a = 2'd0; start_a = 1'b1;
    wait_busy_a(10);
    x_in_a = 8'd100; y_in_a = 7'd50; sel_a = 2'd1;
    push_tile(0, 12, 12, 100, 50, 1);
    wait_done_a(base, 400);
    wait_busy_a(10);
    start_a = 1'b0;
    wait_done_a(base + 1, 400);
    check("b2b_done_count", done_cnt_a - base, 2);
    check("b2b_done_to_plot_gap", gap_a, 3);

    // Reset in the middle of a tile aborts with no done
    push_tile(0, 12, 12, 3, 4, 2);
    base = done_cnt_a;
    start_tile_a(3, 4, 2);
    repeat (20) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    check("abort_plot", plot_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_rom_addr", rom_addr_a, 0);
    check("abort_rom_sel", rom_sel_a, 0);
    check("abort_x_out", x_out_a, 0);
    check("abort_y_out", y_out_a, 0);
    check("abort_color", color_a, 0);
    exp_a.delete();
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (200) @(posedge clock);
    check("abort_no_done", done_cnt_a, base);
    check("abort_idle", busy_a, 0);

    // Instance B: 6x6 tile, ROM latency 3
    push_tile(1, 6, 6, 5, 6, 1);
    @(posedge clock); #1;
    x_in_b = 8'd5; y_in_b = 7'd6; sel_b = 2'd1; start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    begin
      int n = 0;
      while (done_cnt_b == 0 && n < 200) begin @(posedge clock); n++; end
    end
    repeat (10) @(posedge clock);
    check("b_done_once", done_cnt_b, 1);
    check("b_first_latency", lat_b, 3);

    repeat (5) @(posedge clock);
    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
